// File: rtl/gb4ed_sng.sv
// gb4ed_sng: stochastic number generator bank for the 4-pixel Gaussian-blur
// Roberts-cross edge detector. It latches 20 pixel intensities on a start
// handshake and then emits LEN cycles of 21 unipolar bitstreams.
//
// Ports:
//   clk, rst (sync, active-high)
//   start / ready   frame request handshake (accepted on start && ready)
//   px[20*WIDTH]    pixel i in px[WIDTH*i +: WIDTH], drives x[i+1]
//   valid, last     stream bit qualifier and final-cycle marker
//   x[20:0]         x[20:1] pixel streams, x[0] 0.5-probability select stream
//
// Build option: define GB4ED_SNG_DECORR_EN to drive x[0] from an independent
// select LFSR (seeded with SEED_C) instead of the pixel LFSR's low bit.

module gb4ed_sng #(
    parameter int               WIDTH  = 8,
    parameter int               LEN    = 255,
    parameter logic [WIDTH-1:0] SEED_P = WIDTH'(8'hB4),
    parameter logic [WIDTH-1:0] SEED_C = WIDTH'(8'h5A)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [20*WIDTH-1:0]   px,
    output logic                  ready,
    output logic                  valid,
    output logic [20:0]           x,
    output logic                  last
);

    if (!(WIDTH == 8 || WIDTH == 10)) begin : g_bad_width
        $error("gb4ed_sng: WIDTH must be 8 or 10");
    end
    if (LEN < 1 || LEN > 65535) begin : g_bad_len
        $error("gb4ed_sng: LEN must be in 1..65535");
    end

    // An all-zero seed would lock the LFSR, so it is bumped to 1.
    localparam logic [WIDTH-1:0] SEED_P_I =
        (SEED_P == '0) ? WIDTH'(1) : SEED_P;
    localparam logic [WIDTH-1:0] TAP_P =
        (WIDTH == 8) ? WIDTH'(8'hB8) : WIDTH'(10'h240);
    localparam logic [15:0] LAST_CNT = 16'(LEN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [20*WIDTH-1:0] px_q, px_d;
    logic [WIDTH-1:0]    lfsr_p_q, lfsr_p_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [20:0]         x_q, x_d;
    logic [WIDTH-1:0]    r_p;

`ifdef GB4ED_SNG_DECORR_EN
    localparam logic [WIDTH-1:0] SEED_C_I =
        (SEED_C == '0) ? WIDTH'(1) : SEED_C;
    localparam logic [WIDTH-1:0] TAP_C =
        (WIDTH == 8) ? WIDTH'(8'h8E) : WIDTH'(10'h204);
    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0]    lfsr_c_q, lfsr_c_d;
    logic [WIDTH-1:0]    r_c;
`endif

    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        lfsr_p_d = lfsr_p_q;
        cnt_d    = cnt_q;
`ifdef GB4ED_SNG_DECORR_EN
        lfsr_c_d = lfsr_c_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    px_d     = px;
                    lfsr_p_d = SEED_P_I;
                    cnt_d    = '0;
`ifdef GB4ED_SNG_DECORR_EN
                    lfsr_c_d = SEED_C_I;
`endif
                end
            end
            S_RUN: begin
                lfsr_p_d = {lfsr_p_q[WIDTH-2:0], ^(lfsr_p_q & TAP_P)};
                cnt_d    = cnt_q + 16'd1;
`ifdef GB4ED_SNG_DECORR_EN
                lfsr_c_d = {lfsr_c_q[WIDTH-2:0], ^(lfsr_c_q & TAP_C)};
`endif
                if (cnt_q == LAST_CNT) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are computed from next state:
        // the cycle after accept shows the seed-driven comparison.
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RUN);
        last_d  = valid_d && (cnt_d == LAST_CNT);
        r_p     = lfsr_p_d - WIDTH'(1);
        x_d     = '0;
`ifdef GB4ED_SNG_DECORR_EN
        r_c     = lfsr_c_d - WIDTH'(1);
`endif
        if (valid_d) begin
            for (int i = 0; i < 20; i++) begin
                x_d[i+1] = (px_d[WIDTH*i +: WIDTH] > r_p);
            end
`ifdef GB4ED_SNG_DECORR_EN
            x_d[0] = (r_c < HALF);
`else
            x_d[0] = lfsr_p_d[0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            px_q     <= '0;
            lfsr_p_q <= SEED_P_I;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            x_q      <= '0;
`ifdef GB4ED_SNG_DECORR_EN
            lfsr_c_q <= SEED_C_I;
`endif
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            lfsr_p_q <= lfsr_p_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            x_q      <= x_d;
`ifdef GB4ED_SNG_DECORR_EN
            lfsr_c_q <= lfsr_c_d;
`endif
        end
    end

    assign ready = ready_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign x     = x_q;

endmodule
